// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage data memory. Holds a 2**ADDR_W x 32 synchronous RAM and performs
//   word, halfword and byte loads/stores on little-endian lanes. Aligned word
//   stores complete in one cycle; loads and sub-word stores (read-modify-write)
//   take two cycles and raise stall during the first one.
//
// Ports
//   clk        pipeline clock, all state updates on posedge
//   clr        asynchronous active-high reset
//   enable_in  EX/MEM valid; no access starts while low
//   memwrite   store request (wins over memtoreg)
//   memtoreg   load request
//   mode       00 word, 01 halfword, 10 byte, 11 word
//   signext2   1 = sign-extend sub-word load, 0 = zero-extend
//   addr       byte address; bits above ADDR_W+1 are ignored (wraps)
//   wdata      store data, sub-word data from the low bits
//   stall      combinational hold request toward the pipeline
//   load_data  registered load result, holds between loads
//   ld_valid   one-cycle pulse when load_data updates
//   misalign   one-cycle pulse after a misaligned request
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enable_in,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  mode,
  input  logic        signext2,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        ld_valid,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LD, RMW} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_word;

  // Request captured in IDLE so the second cycle does not depend on upstream
  // actually holding its outputs.
  logic [ADDR_W-1:0]   req_idx;
  logic [1:0]          req_lane;
  size_t               req_size;
  logic                req_sext;
  logic [15:0]         req_wdata;

  size_t               cur_size;
  logic                is_store;
  logic                is_load;
  logic                aligned;
  logic                in_idle;
  logic                start_mis;
  logic                start_word_st;
  logic                start_rmw;
  logic                start_ld;
  logic [ADDR_W-1:0]   word_idx;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [31:0]         ram_wdata;
  logic                unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign word_idx         = addr[ADDR_W+1:2];

  function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                               input size_t       sz,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return {{24{sext & b[7]}}, b};
      SZ_HALF: return {{16{sext & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                             input size_t       sz,
                                             input logic [1:0]  lane,
                                             input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE) begin
      m[{lane, 3'b000} +: 8] = d[7:0];
    end else if (lane[1]) begin
      m[31:16] = d;
    end else begin
      m[15:0] = d;
    end
    return m;
  endfunction

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_size = SZ_WORD;
    aligned  = 1'b1;
    case (mode)
      2'b01: begin
        cur_size = SZ_HALF;
        aligned  = ~addr[0];
      end
      2'b10: cur_size = SZ_BYTE;
      default: begin
        cur_size = SZ_WORD;
        aligned  = (addr[1:0] == 2'b00);
      end
    endcase
  end

  assign is_store      = enable_in & memwrite;
  assign is_load       = enable_in & memtoreg & ~memwrite;
  assign in_idle       = (state == IDLE);
  assign start_mis     = in_idle & (is_store | is_load) & ~aligned;
  assign start_word_st = in_idle & is_store & aligned & (cur_size == SZ_WORD);
  assign start_rmw     = in_idle & is_store & aligned & (cur_size != SZ_WORD);
  assign start_ld      = in_idle & is_load & aligned;

  // Gated by clr so an aborted access never writes and stall drops at once.
  assign stall     = ~clr & (start_rmw | start_ld);
  assign ram_re    = start_rmw | start_ld;
  assign ram_we    = ~clr & (start_word_st | (state == RMW));
  assign ram_waddr = (state == RMW) ? req_idx : word_idx;
  assign ram_wdata = (state == RMW) ? merge_lane(rd_word, req_size, req_lane, req_wdata)
                                    : wdata;

  // NOTE: the RAM array has no reset; contents are undefined after clr and
  // a reset branch here would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) rd_word <= mem[word_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      load_data <= '0;
      ld_valid  <= 1'b0;
      misalign  <= 1'b0;
      req_idx   <= '0;
      req_lane  <= '0;
      req_size  <= SZ_WORD;
      req_sext  <= 1'b0;
      req_wdata <= '0;
    end else begin
      ld_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mis) begin
            misalign <= 1'b1;
            if (is_load) begin
              ld_valid  <= 1'b1;
              load_data <= '0;
            end
          end else if (start_ld) begin
            state <= LD;
          end else if (start_rmw) begin
            state <= RMW;
          end
          if (start_ld | start_rmw) begin
            req_idx   <= word_idx;
            req_lane  <= addr[1:0];
            req_size  <= cur_size;
            req_sext  <= signext2;
            req_wdata <= wdata[15:0];
          end
        end
        LD: begin
          load_data <= extract_lane(rd_word, req_size, req_lane, req_sext);
          ld_valid  <= 1'b1;
          state     <= IDLE;
        end
        RMW:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Drives directed and random requests into mem_access_unit. A word-array
//   model of the RAM plus per-request expectations are compared against the
//   DUT outputs on every falling edge; literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        clr;
  logic        enable_in;
  logic        memwrite;
  logic        memtoreg;
  logic [1:0]  mode;
  logic        signext2;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        ld_valid;
  logic        misalign;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .enable_in (enable_in),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .mode      (mode),
    .signext2  (signext2),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .load_data (load_data),
    .ld_valid  (ld_valid),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_on  = 1'b0;

  logic [31:0] model_mem [DEPTH];
  logic        exp_stall     = 1'b0;
  logic        exp_ld_valid  = 1'b0;
  logic        exp_misalign  = 1'b0;
  logic [31:0] exp_load_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall",     {31'b0, stall},    {31'b0, exp_stall});
      check("ld_valid",  {31'b0, ld_valid}, {31'b0, exp_ld_valid});
      check("misalign",  {31'b0, misalign}, {31'b0, exp_misalign});
      check("load_data", load_data,         exp_load_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [1:0] md);
    if (md == 2'b01) return 2;
    if (md == 2'b10) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] model_extract(input logic [31:0] w, input int sz,
                                                input int off, input bit sx);
    logic [31:0] m;
    logic [31:0] v;
    if (sz == 4) return w;
    m = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (w >> (8 * off)) & m;
    if (sx && ((v & ((m >> 1) + 32'd1)) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input int sz,
                                              input int off, input logic [31:0] d);
    logic [31:0] m;
    m = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  // Issues one request starting in the current (IDLE) cycle and advances the
  // expectations through its completion; returns in the first cycle where a
  // new request may be presented.
  task automatic run_req(input bit en, input bit we, input bit re, input logic [1:0] md,
                         input bit sx, input logic [31:0] a, input logic [31:0] wd);
    int sz, off, idx;
    bit is_st, is_ld, mis, multi;
    sz    = size_of(md);
    off   = int'(a[1:0]);
    idx   = int'((a >> 2) % DEPTH);
    is_st = en && we;
    is_ld = en && re && !we;
    mis   = (is_st || is_ld) && ((sz == 4 && off != 0) || (sz == 2 && a[0]));
    multi = !mis && (is_ld || (is_st && sz != 4));

    enable_in = en;
    memwrite  = we;
    memtoreg  = re;
    mode      = md;
    signext2  = sx;
    addr      = a;
    wdata     = wd;
    exp_stall = multi;

    step();
    exp_stall    = 1'b0;
    exp_misalign = mis;
    exp_ld_valid = mis && is_ld;
    if (mis && is_ld) exp_load_data = 32'h0;
    if (is_st && !mis && sz == 4) model_mem[idx] = wd;

    if (multi) begin
      step();
      exp_misalign = 1'b0;
      exp_ld_valid = is_ld;
      if (is_ld) exp_load_data = model_extract(model_mem[idx], sz, off, sx);
      else       model_mem[idx] = model_merge(model_mem[idx], sz, off, wd);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rm;

    clr       = 1'b1;
    enable_in = 1'b1;
    memwrite  = 1'b0;
    memtoreg  = 1'b1;
    mode      = 2'b00;
    signext2  = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    repeat (3) @(posedge clk);
    #3;
    // A valid load is presented during reset: stall must still read 0.
    check("rst_stall",     {31'b0, stall},    32'h0);
    check("rst_ld_valid",  {31'b0, ld_valid}, 32'h0);
    check("rst_misalign",  {31'b0, misalign}, 32'h0);
    check("rst_load_data", load_data,         32'h0);
    enable_in = 1'b0;
    memtoreg  = 1'b0;
    step();
    clr    = 1'b0;
    chk_on = 1'b1;

    for (int i = 0; i < DEPTH; i++) run_req(1, 1, 0, 2'b00, 0, i << 2, $urandom);

    run_req(1, 1, 0, 2'b00, 0, 32'h10, 32'hDEADBEEF);
    run_req(1, 0, 1, 2'b00, 0, 32'h10, 32'h0);
    check("lit_word_load", load_data, 32'hDEADBEEF);
    check("lit_word_ldv",  {31'b0, ld_valid}, 32'h1);

    run_req(1, 1, 0, 2'b10, 0, 32'h11, 32'h000000AA);
    run_req(1, 0, 1, 2'b00, 0, 32'h10, 32'h0);
    check("lit_byte_store", load_data, 32'hDEADAAEF);

    run_req(1, 0, 1, 2'b10, 1, 32'h13, 32'h0);
    check("lit_byte_sext", load_data, 32'hFFFFFFDE);
    run_req(1, 0, 1, 2'b10, 0, 32'h13, 32'h0);
    check("lit_byte_zext", load_data, 32'h000000DE);
    run_req(1, 0, 1, 2'b01, 1, 32'h12, 32'h0);
    check("lit_half_sext", load_data, 32'hFFFFDEAD);

    run_req(1, 1, 0, 2'b01, 0, 32'h13, 32'h00001234);
    check("lit_mis_store", {31'b0, misalign}, 32'h1);
    run_req(1, 0, 1, 2'b00, 0, 32'h10, 32'h0);
    check("lit_mis_unchanged", load_data, 32'hDEADAAEF);
    run_req(1, 0, 1, 2'b00, 0, 32'h01, 32'h0);
    check("lit_mis_load_flag", {31'b0, misalign}, 32'h1);
    check("lit_mis_load_ldv",  {31'b0, ld_valid}, 32'h1);
    check("lit_mis_load_data", load_data, 32'h0);

    // Abort a read-modify-write with clr in its second cycle.
    run_req(1, 1, 0, 2'b00, 0, 32'h20, 32'h11223344);
    chk_on    = 1'b0;
    enable_in = 1'b1;
    memwrite  = 1'b1;
    memtoreg  = 1'b0;
    mode      = 2'b10;
    addr      = 32'h20;
    wdata     = 32'h00000055;
    step();
    clr = 1'b1;
    #2;
    check("clr_stall",     {31'b0, stall},    32'h0);
    check("clr_ld_valid",  {31'b0, ld_valid}, 32'h0);
    check("clr_misalign",  {31'b0, misalign}, 32'h0);
    check("clr_load_data", load_data,         32'h0);
    enable_in = 1'b0;
    memwrite  = 1'b0;
    step();
    clr           = 1'b0;
    exp_stall     = 1'b0;
    exp_ld_valid  = 1'b0;
    exp_misalign  = 1'b0;
    exp_load_data = 32'h0;
    chk_on        = 1'b1;
    run_req(1, 0, 1, 2'b00, 0, 32'h20, 32'h0);
    check("lit_clr_no_write", load_data, 32'h11223344);

    run_req(1, 1, 0, 2'b00, 0, (32'd4 << ADDR_W) + 32'd4, 32'h5A5A5A5A);
    run_req(1, 0, 1, 2'b00, 0, 32'h4, 32'h0);
    check("lit_wrap", load_data, 32'h5A5A5A5A);

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_req($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rm, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    run_req(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
